// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: sequencer states and nibble width
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/adder_cla_4bit.sv
// rtl/adder_cla_4bit.sv - 4-bit carry-lookahead adder slice with carry-out and signed overflow
module adder_cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovfl
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovfl = c[4] ^ c[3];

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - nibble-serial add/subtract sequencer with valid/ready handshakes
// and optional saturation on signed overflow; one 4-bit CLA slice is time-shared.
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl
);

  localparam int NUM_NIB = WIDTH / NIBBLE_W;
  localparam int NIB_CW  = $clog2(NUM_NIB);
  localparam int IDX_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                carry_q, carry_d;
  logic                sat_q, sat_d;
  logic [NIB_CW-1:0]   nib_q, nib_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovfl_q, ovfl_d;

  logic [IDX_W-1:0]    base;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                slice_ovfl;
  logic                last_nib;

  // Bit offset of the current nibble; {nib, 2'b00} is exactly $clog2(WIDTH) bits wide.
  assign base     = {nib_q, 2'b00};
  assign slice_a  = a_q[base +: NIBBLE_W];
  assign slice_b  = b_q[base +: NIBBLE_W];
  assign last_nib = (nib_q == NIB_CW'(NUM_NIB - 1));

  adder_cla_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .ovfl (slice_ovfl)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sat_d   = sat_q;
    nib_d   = nib_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovfl_d  = ovfl_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          sat_d   = sat_en;
          nib_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: NIBBLE_W] = slice_sum;
        carry_d                 = slice_cout;
        if (last_nib) begin
          cout_d  = slice_cout;
          ovfl_d  = slice_ovfl;
          if (sat_q && slice_ovfl) begin
            sum_d = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
          end
          state_d = DONE;
        end else begin
          nib_d = nib_q + NIB_CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      nib_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sat_q   <= sat_d;
      nib_q   <= nib_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovfl      = ovfl_q;

endmodule
